ow_master_ctrl: RTL and testbench

OW_MASTER_CTRL -- requirements
Module: ow_master_ctrl

---
 rtl/ow_master_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ow_master_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ow_master_ctrl.sv
// 1-Wire bus master: executes RESET/presence, WRITE_BYTE and READ_BYTE commands
// by sequencing a registered open-drain pull-down with fixed cycle timings.
module ow_master_ctrl #(
    parameter int unsigned T_RST  = 480,
    parameter int unsigned T_PD   = 70,
    parameter int unsigned T_SLOT = 60,
    parameter int unsigned T_LOW1 = 6,
    parameter int unsigned T_RDS  = 15,
    parameter int unsigned T_REC  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       bus_in,
    output logic       bus_drive_low,
    output logic [7:0] rd_data,
    output logic       presence,
    output logic       done,
    output logic       busy
);

    localparam int unsigned SLOT_TOT = T_SLOT + T_REC;
    localparam int unsigned CNT_MAX  = (T_RST > SLOT_TOT) ? T_RST : SLOT_TOT;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_HIGH,
        S_SLOT_LOW,
        S_SLOT_HIGH,
        S_REC
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [1:0]    cmd_q, cmd_d;
    logic [7:0]    wr_q, wr_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rd_d;
    logic          drive_d, ready_d, busy_d, done_d, pres_d;
    logic          accept;
    logic [CW-1:0] low_last;

    assign accept = cmd_valid && (state == S_IDLE);

    // A write-0 holds the line for almost the whole slot; write-1 and read use the short pulse.
    assign low_last = (cmd_q == CMD_WRITE && !wr_q[idx]) ? CW'(T_SLOT - 2) : CW'(T_LOW1 - 1);

    // State and all registered outputs; cnt counts cycles within a phase (whole slot for bytes).
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            cmd_q         <= '0;
            wr_q          <= '0;
            shift_q       <= '0;
            bus_drive_low <= 1'b0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            presence      <= 1'b0;
            rd_data       <= 8'h00;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            idx           <= idx_next;
            cmd_q         <= cmd_d;
            wr_q          <= wr_d;
            shift_q       <= shift_d;
            bus_drive_low <= drive_d;
            cmd_ready     <= ready_d;
            busy          <= busy_d;
            done          <= done_d;
            presence      <= pres_d;
            rd_data       <= rd_d;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        idx_next   = idx;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (accept) begin
                    case (cmd)
                        CMD_RESET: state_next = S_RST_LOW;
                        CMD_WRITE,
                        CMD_READ:  state_next = S_SLOT_LOW;
                        default:   state_next = S_IDLE;
                    endcase
                end
            end
            S_RST_LOW: begin
                if (cnt == CW'(T_RST - 1)) begin
                    state_next = S_RST_HIGH;
                    cnt_next   = '0;
                end
            end
            S_RST_HIGH: begin
                if (cnt == CW'(T_RST - 1)) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            S_SLOT_LOW: begin
                if (cnt == low_last) state_next = S_SLOT_HIGH;
            end
            S_SLOT_HIGH: begin
                if (cnt == CW'(T_SLOT - 1)) state_next = S_REC;
            end
            S_REC: begin
                if (cnt == CW'(SLOT_TOT - 1)) begin
                    cnt_next   = '0;
                    idx_next   = idx + 3'd1;
                    state_next = (idx == 3'd7) ? S_IDLE : S_SLOT_LOW;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Output/data next values, aligned so each register reflects the state it enters.
    always_comb begin
        cmd_d   = cmd_q;
        wr_d    = wr_q;
        shift_d = shift_q;
        rd_d    = rd_data;
        pres_d  = presence;
        done_d  = 1'b0;
        drive_d = (state_next == S_RST_LOW) || (state_next == S_SLOT_LOW);
        ready_d = (state_next == S_IDLE);
        busy_d  = (state_next != S_IDLE);

        if (accept) begin
            cmd_d = cmd;
            wr_d  = wr_data;
            if (cmd == CMD_RSVD) done_d = 1'b1;
        end

        if (state == S_RST_HIGH && cnt == CW'(T_PD - 1)) pres_d = ~bus_in;

        if ((state == S_SLOT_LOW || state == S_SLOT_HIGH) && cmd_q == CMD_READ
            && cnt == CW'(T_RDS)) begin
            shift_d[idx] = bus_in;
        end

        if ((state == S_RST_HIGH || state == S_REC) && state_next == S_IDLE) begin
            done_d = 1'b1;
            if (state == S_REC && cmd_q == CMD_READ) rd_d = shift_d;
        end
    end

endmodule

// File: tb/tb_ow_master_ctrl.sv
// Directed bench for ow_master_ctrl: an open-drain bus model (device pulls and
// presence pulse) plus a pulse-width monitor, with hand-computed expectations.
module tb_ow_master_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] wr_data = 8'h00;
    logic       bus_in = 1'b1;
    logic       cmd_ready, bus_drive_low, presence, done, busy;
    logic [7:0] rd_data;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;

    ow_master_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .wr_data       (wr_data),
        .bus_in        (bus_in),
        .bus_drive_low (bus_drive_low),
        .rd_data       (rd_data),
        .presence      (presence),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus model and low-pulse monitor, evaluated mid-cycle.
    int         pw[64];
    int         pstart[64];
    int         pcount   = 0;
    int         run      = 0;
    logic       prev_drv = 1'b0;
    int         rise_cnt = 0;
    int         rd_base  = 0;
    logic       read_en  = 1'b0;
    logic [7:0] read_mask = 8'h00;
    logic       pres_mode = 1'b0;
    int         dev_cnt  = 0;
    logic       dev_low  = 1'b0;
    int         rh       = 1000;

    always @(negedge clk) begin
        int rel;
        if (bus_drive_low) begin
            if (!prev_drv) begin
                if (pcount < 64) pstart[pcount] = cyc;
                rise_cnt = rise_cnt + 1;
                rel = rise_cnt - rd_base - 1;
                if (read_en && rel >= 0 && rel < 8 && read_mask[rel[2:0]]) dev_cnt = 31;
            end
            run = run + 1;
        end else if (prev_drv) begin
            if (pcount < 64) pw[pcount] = run;
            pcount = pcount + 1;
            run = 0;
        end
        if (dev_cnt > 0) begin
            dev_low = 1'b1;
            dev_cnt = dev_cnt - 1;
        end else begin
            dev_low = 1'b0;
        end
        if (!bus_drive_low && prev_drv) rh = 0;
        else rh = rh + 1;
        bus_in   = ~(bus_drive_low | dev_low | (pres_mode && rh >= 60 && rh <= 180));
        prev_drv = bus_drive_low;
    end

    task automatic accept(input logic [1:0] c, input logic [7:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd       = c;
        wr_data   = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 2000) begin
            @(posedge clk); #1;
            lat = lat + 1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({bus_drive_low, cmd_ready, busy, done, presence, rd_data} !== {5'b01000, 8'h00}) begin
            errs++;
            $display("FAIL reset_state: got drv/rdy/busy/done/pres/rd=%b %h, want 01000 00",
                     {bus_drive_low, cmd_ready, busy, done, presence}, rd_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_presence(input logic dev_present);
        int lat;
        int base;
        pres_mode = dev_present;
        base = pcount;
        accept(2'b00, 8'h00);
        vec++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_busy: got busy=%b ready=%b, want 1 0", busy, cmd_ready);
        end
        wait_done(lat);
        vec++;
        if (lat !== 960) begin
            errs++;
            $display("FAIL rst_latency: got %0d, want 960", lat);
        end
        vec++;
        if (presence !== dev_present) begin
            errs++;
            $display("FAIL presence: got %b, want %b", presence, dev_present);
        end
        vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_done_idle: got ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
        vec++;
        if (pcount - base !== 1 || pw[base] !== 480) begin
            errs++;
            $display("FAIL rst_low_width: got %0d pulses width %0d, want 1 pulse width 480",
                     pcount - base, pw[base]);
        end
        pres_mode = 1'b0;
    endtask

    task automatic test_write;
        int lat;
        int base;
        int exp_w[8] = '{6, 59, 6, 59, 59, 6, 59, 6};
        base = pcount;
        accept(2'b01, 8'hA5);
        wait_done(lat);
        vec++;
        if (lat !== 520) begin
            errs++;
            $display("FAIL wr_latency: got %0d, want 520", lat);
        end
        vec++;
        if (pcount - base !== 8) begin
            errs++;
            $display("FAIL wr_pulse_count: got %0d, want 8", pcount - base);
        end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (pw[base + i] !== exp_w[i]) begin
                errs++;
                $display("FAIL wr_width[%0d]: got %0d, want %0d", i, pw[base + i], exp_w[i]);
            end
        end
        for (int i = 0; i < 7; i++) begin
            vec++;
            if (pstart[base + i + 1] - pstart[base + i] !== 65) begin
                errs++;
                $display("FAIL wr_period[%0d]: got %0d, want 65", i,
                         pstart[base + i + 1] - pstart[base + i]);
            end
        end
        vec++;
        if (rd_data !== 8'h00 || presence !== 1'b0) begin
            errs++;
            $display("FAIL wr_side_effect: got rd=%h pres=%b, want 00 0", rd_data, presence);
        end
    endtask

    task automatic test_read;
        int base;
        read_mask = 8'b1001_0010;
        rd_base   = rise_cnt;
        read_en   = 1'b1;
        base      = pcount;
        accept(2'b10, 8'h00);
        repeat (519) @(posedge clk);
        #1;
        vec++;
        if (rd_data !== 8'h00 || done !== 1'b0) begin
            errs++;
            $display("FAIL rd_early: got rd=%h done=%b, want 00 0", rd_data, done);
        end
        @(posedge clk); #1;
        vec++;
        if (done !== 1'b1 || rd_data !== 8'h6D) begin
            errs++;
            $display("FAIL rd_result: got done=%b rd=%h, want 1 6d", done, rd_data);
        end
        @(posedge clk); #1;
        vec++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL rd_done_pulse: got done=%b one cycle later, want 0", done);
        end
        vec++;
        if (pcount - base !== 8) begin
            errs++;
            $display("FAIL rd_pulse_count: got %0d, want 8", pcount - base);
        end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (pw[base + i] !== 6) begin
                errs++;
                $display("FAIL rd_width[%0d]: got %0d, want 6", i, pw[base + i]);
            end
        end
        read_en = 1'b0;
    endtask

    task automatic test_reserved_and_ignore;
        int lat;
        int base;
        logic [1:0] noise[3] = '{2'b00, 2'b11, 2'b10};
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd       = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vec++;
            if (done !== 1'b1 || busy !== 1'b0 || bus_drive_low !== 1'b0) begin
                errs++;
                $display("FAIL rsvd[%0d]: got done=%b busy=%b drv=%b, want 1 0 0",
                         i, done, busy, bus_drive_low);
            end
        end
        cmd     = 2'b01;
        wr_data = 8'hFF;
        base    = pcount;
        @(posedge clk); #1;
        vec++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL ign_accept: got busy=%b, want 1", busy);
        end
        lat = 0;
        while (!done && lat < 2000) begin
            cmd_valid = (lat < 500) ? ~cmd_valid : 1'b0;
            cmd       = noise[lat % 3];
            wr_data   = 8'(lat);
            @(posedge clk); #1;
            lat = lat + 1;
        end
        cmd_valid = 1'b0;
        vec++;
        if (lat !== 520) begin
            errs++;
            $display("FAIL ign_latency: got %0d, want 520", lat);
        end
        vec++;
        if (pcount - base !== 8 || pw[base] !== 6 || pw[base + 1] !== 6 || pw[base + 7] !== 6) begin
            errs++;
            $display("FAIL ign_pattern: got %0d pulses w0=%0d w1=%0d w7=%0d, want 8 of 6",
                     pcount - base, pw[base], pw[base + 1], pw[base + 7]);
        end
        vec++;
        if (rd_data !== 8'h6D || presence !== 1'b0) begin
            errs++;
            $display("FAIL ign_hold: got rd=%h pres=%b, want 6d 0", rd_data, presence);
        end
        repeat (5) @(posedge clk);
        #1;
        vec++;
        if (busy !== 1'b0 || bus_drive_low !== 1'b0) begin
            errs++;
            $display("FAIL ign_no_queue: got busy=%b drv=%b, want 0 0", busy, bus_drive_low);
        end
    endtask

    task automatic test_abort;
        int   lat;
        logic saw_done;
        pres_mode = 1'b1;
        test_presence(1'b1);
        accept(2'b01, 8'hA5);
        repeat (199) @(posedge clk);
        #1;
        vec++;
        if (bus_drive_low !== 1'b1) begin
            errs++;
            $display("FAIL abort_pre: got drv=%b, want 1", bus_drive_low);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vec++;
        if ({bus_drive_low, cmd_ready, busy, done, presence, rd_data} !== {5'b01000, 8'h00}) begin
            errs++;
            $display("FAIL abort_state: got drv/rdy/busy/done/pres/rd=%b %h, want 01000 00",
                     {bus_drive_low, cmd_ready, busy, done, presence}, rd_data);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (done || bus_drive_low) saw_done = 1'b1;
        end
        vec++;
        if (saw_done !== 1'b0) begin
            errs++;
            $display("FAIL abort_quiet: got activity=%b after abort, want 0", saw_done);
        end
        accept(2'b00, 8'h00);
        wait_done(lat);
        vec++;
        if (lat !== 960 || presence !== 1'b0) begin
            errs++;
            $display("FAIL abort_restart: got lat=%0d pres=%b, want 960 0", lat, presence);
        end
    endtask

    initial begin
        test_reset();
        test_presence(1'b1);
        test_presence(1'b0);
        test_write();
        test_read();
        test_reserved_and_ignore();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
